line_burst_adaptor: RTL and testbench

Converts the single-transfer 256-bit cache-line interface leaving the L2 eviction write buffer into the 4-beat, 64-bit burst protocol of physical memory. Sits directly downstream of the top-level memory subsystem's `read`/`write`/`address`/`wdata`/`resp`/`rdata` port: it consumes full-line requests and serialises or deserialises them beat by beat. It holds at most one line transaction in flight.

---
 rtl/line_adaptor_pkg.sv | 21 ++
 rtl/line_adaptor_perf.sv | 49 ++++
 rtl/line_burst_adaptor.sv | 125 ++++++++++++
 tb/tb_line_burst_adaptor.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_adaptor_pkg.sv
// Shared types and constants for the line-to-burst adaptor.
// Build option LINE_ADAPTOR_PERF_EN is consumed by line_burst_adaptor.
package line_adaptor_pkg;

    localparam int LINE_W_DEF    = 256;
    localparam int BEAT_W_DEF    = 64;
    localparam int ADDR_W_DEF    = 32;
    localparam int BEATS         = LINE_W_DEF / BEAT_W_DEF;
    localparam int BEAT_IDX_W    = $clog2(BEATS);
    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_BURST = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_WR_BURST = 3'd4,
        ST_DONE     = 3'd5
    } adaptor_state_t;

endpackage

// File: rtl/line_adaptor_perf.sv
// Saturating transaction and stall counters for the line adaptor,
// derived purely from the adaptor state and its completion pulse.
module line_adaptor_perf
    import line_adaptor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic        resp,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] stall_count
);

    localparam logic [31:0] SAT = 32'hFFFF_FFFF;

    adaptor_state_t st;
    logic           last_wr;
    logic           in_wait;

    assign st      = adaptor_state_t'(state);
    assign in_wait = (st == ST_RD_WAIT) || (st == ST_WR_WAIT);

    // DONE carries no direction, so remember which WAIT state led into it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_wr     <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (st == ST_WR_WAIT) begin
                last_wr <= 1'b1;
            end else if (st == ST_RD_WAIT) begin
                last_wr <= 1'b0;
            end
            if (in_wait && stall_count != SAT) begin
                stall_count <= stall_count + 32'd1;
            end
            if (resp && !last_wr && rd_count != SAT) begin
                rd_count <= rd_count + 32'd1;
            end
            if (resp && last_wr && wr_count != SAT) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/line_burst_adaptor.sv
// Serialises/deserialises one cache line into a BEATS-beat memory burst.
// Define LINE_ADAPTOR_PERF_EN to add rd_count/wr_count/stall_count outputs.
module line_burst_adaptor
    import line_adaptor_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [LINE_W-1:0] wdata,
    output logic              resp,
    output logic [LINE_W-1:0] rdata,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [BEAT_W-1:0] burst_o,
    input  logic [BEAT_W-1:0] burst_i,
    input  logic              resp_i,
`ifdef LINE_ADAPTOR_PERF_EN
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic [31:0]       stall_count,
`endif
    output logic [2:0]        dbg_state
);

    localparam int NB    = LINE_W / BEAT_W;
    localparam int IDX_W = $clog2(NB);

    adaptor_state_t    state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic              load_addr;
    logic              load_wdata;
    logic              capture;

    // Counter advances only on resp_i, so a gap in the strobe simply holds the FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_addr  = 1'b0;
        load_wdata = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (write) begin
                    load_addr  = 1'b1;
                    load_wdata = 1'b1;
                    state_d    = ST_WR_WAIT;
                end else if (read) begin
                    load_addr = 1'b1;
                    state_d   = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (resp_i) begin
                    capture = (state_q == ST_RD_WAIT);
                    cnt_d   = cnt_q + IDX_W'(1);
                    state_d = (state_q == ST_RD_WAIT) ? ST_RD_BURST : ST_WR_BURST;
                end
            end
            ST_RD_BURST, ST_WR_BURST: begin
                if (resp_i) begin
                    capture = (state_q == ST_RD_BURST);
                    cnt_d   = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(NB - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_addr) begin
                addr_q <= {address[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
            end
            if (load_wdata) begin
                wdata_q <= wdata;
            end
            if (capture) begin
                rdata_q[BEAT_W*cnt_q +: BEAT_W] <= burst_i;
            end
        end
    end

    assign resp      = (state_q == ST_DONE);
    assign read_o    = (state_q == ST_RD_WAIT);
    assign write_o   = (state_q == ST_WR_WAIT);
    assign address_o = addr_q;
    assign burst_o   = wdata_q[BEAT_W*cnt_q +: BEAT_W];
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

`ifdef LINE_ADAPTOR_PERF_EN
    line_adaptor_perf u_perf (
        .clk         (clk),
        .rst         (reset),
        .state       (state_q),
        .resp        (resp),
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: the driver plays the memory side,
// a monitor pops expected {rdata, address_o} pairs on every resp pulse.
module tb_line_burst_adaptor;
    import line_adaptor_pkg::*;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          read, write;
    logic [AW-1:0] address;
    logic [LW-1:0] wdata;
    logic          resp;
    logic [LW-1:0] rdata;
    logic [AW-1:0] address_o;
    logic          read_o, write_o;
    logic [BW-1:0] burst_o, burst_i;
    logic          resp_i;
    logic [2:0]    dbg_state;
`ifdef LINE_ADAPTOR_PERF_EN
    logic [31:0]   rd_count, wr_count, stall_count;
`endif

    line_burst_adaptor dut (
        .clk         (clk),
        .reset       (reset),
        .read        (read),
        .write       (write),
        .address     (address),
        .wdata       (wdata),
        .resp        (resp),
        .rdata       (rdata),
        .address_o   (address_o),
        .read_o      (read_o),
        .write_o     (write_o),
        .burst_o     (burst_o),
        .burst_i     (burst_i),
        .resp_i      (resp_i),
`ifdef LINE_ADAPTOR_PERF_EN
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .stall_count (stall_count),
`endif
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int               checks   = 0;
    int               failures = 0;
    logic [LW+AW-1:0] exp_q[$];
    logic [LW+AW-1:0] mon_e;
    logic [LW-1:0]    last_line;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory side of one burst; entered in the first WAIT cycle, returns in DONE
    task automatic serve(input bit is_wr, input logic [LW-1:0] line, input int delay);
        for (int i = 0; i < delay; i++) begin
            chk1(is_wr ? "wait_write_o" : "wait_read_o", is_wr ? write_o : read_o, 1'b1);
            if (is_wr) chk("wait_burst_o", LW'(burst_o), LW'(line[BW-1:0]));
            step();
        end
        for (int k = 0; k < 4; k++) begin
            resp_i  = 1'b1;
            burst_i = is_wr ? '0 : line[k*BW +: BW];
            if (is_wr) chk("beat_burst_o", LW'(burst_o), LW'(line[k*BW +: BW]));
            step();
            if (k == 0) chk1("req_drop", is_wr ? write_o : read_o, 1'b0);
        end
        resp_i  = 1'b0;
        burst_i = '0;
        chk1("done_resp", resp, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!reset && resp) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got resp=1 expected no response");
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_rdata", rdata, mon_e[LW+AW-1:AW]);
                chk("resp_address_o", LW'(address_o), LW'(mon_e[AW-1:0]));
            end
        end
    end

    localparam logic [LW-1:0] LINE_A = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    localparam logic [LW-1:0] LINE_D = {64'hD3D3_0000_0000_00D3, 64'hD2D2_0000_0000_00D2,
                                        64'hD1D1_0000_0000_00D1, 64'hD0D0_0000_0000_00D0};
    localparam logic [LW-1:0] LINE_E = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
    localparam logic [LW-1:0] LINE_F = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
    localparam logic [LW-1:0] LINE_G = {64'h1111_0003, 64'h1111_0002, 64'h1111_0001, 64'h1111_0000};
    localparam logic [LW-1:0] LINE_H = {64'h2222_0003, 64'h2222_0002, 64'h2222_0001, 64'h2222_0000};
    localparam logic [LW-1:0] LINE_R = {64'hBAD3, 64'hBAD2, 64'hBAD1, 64'hBAD0};
    localparam logic [LW-1:0] LINE_N = {64'h5553, 64'h5552, 64'h5551, 64'h5550};
    localparam logic [LW-1:0] LINE_P = {64'h7773, 64'h7772, 64'h7771, 64'h7770};

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; wdata = '0;
        burst_i = '0; resp_i = 1'b0; last_line = '0;
        step();
        step();
        chk1("rst_resp", resp, 1'b0);
        chk1("rst_read_o", read_o, 1'b0);
        chk1("rst_write_o", write_o, 1'b0);
        chk("rst_address_o", LW'(address_o), '0);
        chk("rst_burst_o", LW'(burst_o), '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_state", LW'(dbg_state), LW'(ST_IDLE));
        reset = 1'b0;
        step();

        // Read 0x1234, memory answers at cycle 3, resp at cycle 7
        address = 32'h0000_1234; read = 1'b1;
        exp_q.push_back({LINE_A, 32'h0000_1220}); last_line = LINE_A;
        step();
        chk("rd_address_o", LW'(address_o), LW'(32'h0000_1220));
        chk1("rd_write_o_low", write_o, 1'b0);
        serve(1'b0, LINE_A, 2);
        read = 1'b0;
        step();
        chk("rd_back_idle", LW'(dbg_state), LW'(ST_IDLE));
        chk1("rd_resp_one_cycle", resp, 1'b0);

        // Write 0x8000_0040; rdata must keep the previous read line
        address = 32'h8000_0040; wdata = LINE_D; write = 1'b1;
        exp_q.push_back({last_line, 32'h8000_0040});
        step();
        chk1("wr_write_o", write_o, 1'b1);
        chk1("wr_read_o_low", read_o, 1'b0);
        chk("wr_burst_o_first", LW'(burst_o), LW'(LINE_D[BW-1:0]));
        serve(1'b1, LINE_D, 1);
        write = 1'b0;
        step();

        // Read and write together: write first, held read afterwards
        address = 32'h0000_2000; wdata = LINE_E; write = 1'b1; read = 1'b1;
        exp_q.push_back({last_line, 32'h0000_2000});
        step();
        chk1("both_write_o", write_o, 1'b1);
        chk1("both_read_o", read_o, 1'b0);
        serve(1'b1, LINE_E, 0);
        write = 1'b0;
        exp_q.push_back({LINE_F, 32'h0000_2000}); last_line = LINE_F;
        step();
        chk1("both_idle_read_o", read_o, 1'b0);
        step();
        chk1("both_then_read_o", read_o, 1'b1);
        serve(1'b0, LINE_F, 0);
        read = 1'b0;
        step();

        // Back-to-back reads with read held continuously
        address = 32'h3000_0100; read = 1'b1;
        exp_q.push_back({LINE_G, 32'h3000_0100});
        step();
        serve(1'b0, LINE_G, 1);
        chk1("b2b_done_no_dup", read_o, 1'b0);
        exp_q.push_back({LINE_H, 32'h3000_0100}); last_line = LINE_H;
        step();
        chk1("b2b_idle_read_o", read_o, 1'b0);
        step();
        chk1("b2b_second_read_o", read_o, 1'b1);
        serve(1'b0, LINE_H, 0);
        read = 1'b0;
        step();

        // Strobe gap mid-burst: FSM holds, then completes normally
        address = 32'h0000_6000; read = 1'b1;
        exp_q.push_back({LINE_P, 32'h0000_6000}); last_line = LINE_P;
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                resp_i = 1'b0;
                step();
                step();
                chk1("gap_no_resp", resp, 1'b0);
                chk("gap_hold_state", LW'(dbg_state), LW'(ST_RD_BURST));
            end
            resp_i = 1'b1; burst_i = LINE_P[k*BW +: BW];
            step();
        end
        resp_i = 1'b0; burst_i = '0; read = 1'b0;
        chk1("gap_resp", resp, 1'b1);
        step();

        // Reset in RD_BURST after beat 1
        address = 32'h0000_4000; read = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            resp_i = 1'b1; burst_i = LINE_R[k*BW +: BW];
            step();
        end
        read = 1'b0; resp_i = 1'b0; burst_i = '0;
        #2 reset = 1'b1;
        #1;
        chk1("mid_rst_resp", resp, 1'b0);
        chk1("mid_rst_read_o", read_o, 1'b0);
        chk("mid_rst_address_o", LW'(address_o), '0);
        chk("mid_rst_burst_o", LW'(burst_o), '0);
        chk("mid_rst_rdata", rdata, '0);
        chk("mid_rst_state", LW'(dbg_state), LW'(ST_IDLE));
        step();
        reset = 1'b0; last_line = '0;
        step();

        // Fresh read after reset, unaligned address
        address = 32'h0000_5037; read = 1'b1;
        exp_q.push_back({LINE_N, 32'h0000_5020}); last_line = LINE_N;
        step();
        serve(1'b0, LINE_N, 0);
        read = 1'b0;
        step();

`ifdef LINE_ADAPTOR_PERF_EN
        reset = 1'b1;
        step();
        reset = 1'b0; last_line = '0;
        step();
        chk("perf_rst_rd", LW'(rd_count), '0);
        for (int t = 0; t < 3; t++) begin
            address = 32'h0000_7000; wdata = LINE_E;
            if (t == 1) write = 1'b1; else read = 1'b1;
            if (t == 1) exp_q.push_back({last_line, 32'h0000_7000});
            else begin
                exp_q.push_back({LINE_G, 32'h0000_7000}); last_line = LINE_G;
            end
            step();
            serve(t == 1, (t == 1) ? LINE_E : LINE_G, 1);
            read = 1'b0; write = 1'b0;
            step();
        end
        chk("perf_rd_count", LW'(rd_count), LW'(32'd2));
        chk("perf_wr_count", LW'(wr_count), LW'(32'd1));
        chk("perf_stall_count", LW'(stall_count), LW'(32'd6));
`endif

        step();
        step();
        chk("queue_drained", LW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
